wide_add_sequencer: RTL
=======================

// Module: wide_add_sequencer
// PURPOSE
// - Upstream/downstream companion of the 8-bit prefix adder: computes a WIDTH-bit add by issuing
//   WIDTH/8 byte slices, LSB first, to one external 8-bit adder instance.
// - Chains the carry between slices in a register and assembles the result.
// - Presents valid/ready handshakes on the operand side and on the result side.
// - Trades latency for area: one 8-bit adder serves any operand width.
// PARAMETERS
// - WIDTH  32  operand/result width; must be a multiple of 8 and >= 16. NSLICE = WIDTH/8 (derived).
// PORTS
// - clk        in   1      rising-edge clock
// - rst        in   1      synchronous reset, active-high
// - in_valid   in   1      operands valid
// - in_ready   out  1      sequencer can accept operands
// - in_a       in   WIDTH  operand A
// - in_b       in   WIDTH  operand B
// - in_cin     in   1      carry-in
// - out_valid  out  1      result valid
// - out_ready  in   1      consumer accepts result
// - out_sum    out  WIDTH  sum
// - out_cout   out  1      carry-out of bit WIDTH-1
// - add_a      out  8      slice of A to the adder's a
// - add_b      out  8      slice of B to the adder's b
// - add_cin    out  1      to the adder's cin
// - add_sum    in   8      from the adder's sum (combinational, same cycle)
// - add_cout   in   1      from the adder's cout (combinational, same cycle)
// BEHAVIOUR
// - Reset values: in_ready=1, out_valid=0, out_sum=0, out_cout=0, add_a=0, add_b=0, add_cin=0.
//   Reset also clears the internal operand, slice-index and carry registers; FSM -> IDLE.
// - FSM states: IDLE, RUN, DONE.
// - IDLE: in_ready=1. On in_valid&&in_ready:
//   - latch in_a, in_b;
//   - carry <= in_cin;
//   - idx <= 0;
//   - go to RUN.
// - RUN: in_ready=0. Each cycle:
//   - drive add_a = A[8*idx+:8], add_b = B[8*idx+:8], add_cin = carry;
//   - at the clock edge: out_sum[8*idx+:8] <= add_sum, carry <= add_cout, idx <= idx+1;
//   - when idx==NSLICE-1: out_cout <= add_cout and go to DONE.
// - DONE: out_valid=1; add_a, add_b and add_cin are driven 0.
//   - out_sum and out_cout are held stable until out_valid&&out_ready; then -> IDLE.
// - Latency: out_valid rises exactly NSLICE cycles after the accept edge.
// - Throughput: one operation per NSLICE+2 cycles when out_ready is tied high.
// - in_ready is deasserted in RUN and DONE; in_valid there is ignored and operands are not sampled.
// - Slices not yet written during RUN keep their previous values; out_sum is valid only when
//   out_valid=1.
// - Arithmetic: {out_cout,out_sum} = in_a + in_b + in_cin, modulo 2^(WIDTH+1); unsigned.
// - Reset asserted in any state, including mid-RUN, takes effect at the next edge:
//   - the operation is discarded and no out_valid is produced;
//   - reset has priority over a simultaneous handshake.
// - idx counter width is clog2(NSLICE); it never wraps beyond NSLICE-1.
// CONFIGURATION
// - ADD_OVF_EN defined: adds output out_ovf (1 bit, reset 0).
//   - Registered with out_cout on the last slice: out_ovf = A[W-1]^B[W-1]^add_sum[7]^add_cout.
//   - This is the two's-complement signed overflow. It is held with out_sum.
// - ADD_OVF_EN undefined: the out_ovf port and its logic are absent; all other behaviour is identical.
// TESTING (WIDTH=32, NSLICE=4)
// - Reset: rst=1 for 2 cycles -> in_ready=1, out_valid=0, out_sum=0, out_cout=0, add_a/add_b/add_cin=0.
// - Full ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 -> out_valid 4 cycles after accept;
//   out_sum=0x00000000, out_cout=1; add_cin=1 on slices 1-3.
// - Carry-in: a=0x12345678, b=0x11111111, cin=1 -> out_sum=0x2345678A, out_cout=0.
// - Backpressure: hold out_ready=0 for 5 cycles after out_valid, pulse in_valid with new operands
//   -> out_sum/out_cout stable, in_ready=0, new operands ignored. Release -> IDLE next cycle.
// - Mid-op reset: rst=1 during RUN at idx=2 -> next cycle IDLE, outputs at reset values,
//   out_valid never asserted. A subsequent add completes correctly.
// - ADD_OVF_EN checks:
//   - a=0x7FFFFFFF, b=0x00000001 -> out_sum=0x80000000, out_ovf=1, out_cout=0.
//   - a=0x80000000, b=0x80000000 -> out_sum=0, out_cout=1, out_ovf=1.
//   - a=0xFFFFFFFF, b=0x00000001 -> out_ovf=0.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Byte-serial WIDTH-bit adder front end driving one external combinational 8-bit adder.
// Optional signed-overflow output out_ovf is enabled by defining ADD_OVF_EN.
module wide_add_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    input  logic             i_in_cin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_sum,
    output logic             o_out_cout,
    output logic [7:0]       o_add_a,
    output logic [7:0]       o_add_b,
    output logic             o_add_cin,
`ifdef ADD_OVF_EN
    output logic             o_out_ovf,
`endif
    input  logic [7:0]       i_add_sum,
    input  logic             i_add_cout
);

    localparam int unsigned NSLICE = WIDTH / 8;
    localparam int unsigned IDXW   = $clog2(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;
`ifdef ADD_OVF_EN
    logic             r_ovf;
`endif

    logic [IDXW+2:0]  w_base;
    logic             w_run;

    assign w_base = {r_idx, 3'b000};
    assign w_run  = (r_state == StRun);

    // Adder inputs are forced to zero outside RUN so the shared adder sees a quiet bus.
    assign o_add_a   = w_run ? r_a[w_base +: 8] : 8'h00;
    assign o_add_b   = w_run ? r_b[w_base +: 8] : 8'h00;
    assign o_add_cin = w_run ? r_carry : 1'b0;

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_sum;
    assign o_out_cout  = r_cout;
`ifdef ADD_OVF_EN
    assign o_out_ovf   = r_ovf;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef ADD_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_a        <= i_in_a;
                        r_b        <= i_in_b;
                        r_carry    <= i_in_cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    r_sum[w_base +: 8] <= i_add_sum;
                    r_carry            <= i_add_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= i_add_cout;
`ifdef ADD_OVF_EN
                        // Carry into the MSB xor carry out of it.
                        r_ovf       <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ i_add_sum[7] ^ i_add_cout;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
